// File: rtl/renkon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : renkon_pkg
//  Description : Shared widths, core-count default and controller state enum.
//  Revision    : 1.0
// ============================================================================
package renkon_pkg;

    localparam int LWIDTH     = 8;
    localparam int N_CORE_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/renkon_ctrl_bus.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_bus
//  Description : Start/valid/stop handshake from the pooling stage.
//  Revision    : 1.0
// ============================================================================
interface ctrl_bus;
    logic start;
    logic valid;
    logic stop;

    modport master (output start, output valid, output stop);
    modport slave  (input  start, input  valid, input  stop);
endinterface
`default_nettype wire

// File: rtl/renkon_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : renkon_wb_queue
//  Description : Two-entry pixel/bank FIFO; head stays resident while it is
//                being serialized and is popped on its last lane.
//  Revision    : 1.0
// ============================================================================
module renkon_wb_queue #(
    parameter int PWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [PWIDTH-1:0] push_pix,
    input  logic              push_bank,
    output logic [PWIDTH-1:0] head_pix,
    output logic              head_bank,
    output logic              empty,
    output logic              full,
    output logic              push_during_pop
);

    logic [PWIDTH-1:0] r_pix0;
    logic [PWIDTH-1:0] r_pix1;
    logic              r_bank0;
    logic              r_bank1;
    logic [1:0]        r_count;
    logic              w_pop;
    logic              w_push;

    assign empty           = (r_count == 2'd0);
    assign full            = (r_count == 2'd2);
    assign w_pop           = pop & ~empty;
    // A pop in the same cycle frees the slot a full queue would otherwise refuse
    assign push_during_pop = full & w_pop;
    assign w_push          = push & (~full | w_pop);
    assign head_pix        = r_pix0;
    assign head_bank       = r_bank0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix0  <= '0;
            r_pix1  <= '0;
            r_bank0 <= 1'b0;
            r_bank1 <= 1'b0;
            r_count <= 2'd0;
        end else if (clr) begin
            r_count <= 2'd0;
        end else begin
            if (w_pop) begin
                r_pix0  <= r_pix1;
                r_bank0 <= r_bank1;
            end
            if (w_push) begin
                if (r_count == 2'd0 || (r_count == 2'd1 && w_pop)) begin
                    r_pix0  <= push_pix;
                    r_bank0 <= push_bank;
                end else begin
                    r_pix1  <= push_pix;
                    r_bank1 <= push_bank;
                end
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/renkon_ctrl_wb.sv
`default_nettype none
// ============================================================================
//  Module      : renkon_ctrl_wb
//  Description : Write-back controller: queues pooled pixels and serializes
//                each one as N_CORE plane-strided memory writes.
//  Revision    : 1.0
// ============================================================================
module renkon_ctrl_wb
    import renkon_pkg::*;
#(
    parameter  int N_CORE = N_CORE_DEF,
    parameter  int AWIDTH = 12,
    localparam int SEL_W  = (N_CORE > 1) ? $clog2(N_CORE) : 1
) (
    input  logic              clk,
    input  logic              xrst,
    ctrl_bus.slave            in_ctrl,
    input  logic [LWIDTH-1:0] out_size,
    input  logic [AWIDTH-1:0] out_base,
    output logic              wb_wbank,
    output logic              wb_rbank,
    output logic [SEL_W-1:0]  wb_sel,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              wb_ack,
    output logic              wb_ovf
);

    localparam int SQ_W = (2 * LWIDTH > AWIDTH) ? 2 * LWIDTH : AWIDTH;

    state_t            r_state;
    state_t            w_next;
    logic [AWIDTH-1:0] r_plane;
    logic [AWIDTH-1:0] r_base;
    logic [AWIDTH-1:0] r_pix;
    logic [AWIDTH-1:0] r_off;
    logic [SEL_W-1:0]  r_lane;
    logic              r_stop_seen;
    logic              r_ovf;
    logic              r_wbank;

    logic [SQ_W-1:0]   w_sq;
    logic              w_start;
    logic              w_active;
    logic              w_busy;
    logic              w_last;
    logic              w_push;
    logic              w_drop;
    logic [AWIDTH-1:0] w_head_pix;
    logic              w_head_bank;
    logic              w_empty;
    logic              w_full;
    logic              w_pdp;

    assign w_sq     = SQ_W'(out_size) * SQ_W'(out_size);
    assign w_start  = (r_state == S_IDLE) & in_ctrl.start;
    assign w_active = (r_state == S_ACTIVE);
    assign w_busy   = w_active & ~w_empty;
    assign w_last   = w_busy & (r_lane == SEL_W'(N_CORE - 1));
    assign w_push   = w_active & in_ctrl.valid & (~w_full | w_pdp);
    assign w_drop   = w_active & in_ctrl.valid & w_full & ~w_pdp;

    renkon_wb_queue #(
        .PWIDTH (AWIDTH)
    ) u_queue (
        .clk             (clk),
        .rst             (xrst),
        .clr             (w_start),
        .push            (w_push),
        .pop             (w_last),
        .push_pix        (r_pix),
        .push_bank       (r_wbank),
        .head_pix        (w_head_pix),
        .head_bank       (w_head_bank),
        .empty           (w_empty),
        .full            (w_full),
        .push_during_pop (w_pdp)
    );

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (in_ctrl.start) w_next = S_ACTIVE;
            S_ACTIVE: if (r_stop_seen && w_empty) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_we   = w_busy;
        wb_sel   = w_busy ? r_lane : '0;
        wb_rbank = w_busy & w_head_bank;
        mem_addr = w_busy ? (r_base + w_head_pix + r_off) : '0;
        wb_ack   = (r_state == S_DONE);
        wb_ovf   = r_ovf;
        wb_wbank = r_wbank;
    end

    // r_off accumulates lane*plane so each lane costs one add, not a multiply
    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            r_plane     <= '0;
            r_base      <= '0;
            r_pix       <= '0;
            r_off       <= '0;
            r_lane      <= '0;
            r_stop_seen <= 1'b0;
            r_ovf       <= 1'b0;
            r_wbank     <= 1'b0;
        end else if (w_start) begin
            r_plane     <= w_sq[AWIDTH-1:0];
            r_base      <= out_base;
            r_pix       <= '0;
            r_off       <= '0;
            r_lane      <= '0;
            r_stop_seen <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_active) begin
            if (w_push) begin
                r_pix   <= r_pix + AWIDTH'(1);
                r_wbank <= ~r_wbank;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (in_ctrl.stop) begin
                r_stop_seen <= 1'b1;
            end
            if (w_busy) begin
                if (w_last) begin
                    r_lane <= '0;
                    r_off  <= '0;
                end else begin
                    r_lane <= r_lane + SEL_W'(1);
                    r_off  <= r_off + r_plane;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_renkon_ctrl_wb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_renkon_ctrl_wb
//  Description : Scoreboard bench for renkon_ctrl_wb (N_CORE=4 and N_CORE=8).
//  Revision    : 1.0
// ============================================================================
module tb_renkon_ctrl_wb;
    import renkon_pkg::*;

    localparam int AW = 12;

    typedef struct {
        int cyc;
        int addr;
        int sel;
        int bank;
    } wr_t;

    logic              clk = 1'b0;
    logic              xrst = 1'b1;
    logic [LWIDTH-1:0] out_size = '0;
    logic [AW-1:0]     out_base = '0;

    logic          wbank4, rbank4, we4, ack4, ovf4;
    logic [1:0]    sel4;
    logic [AW-1:0] addr4;
    logic          wbank8, rbank8, we8, ack8, ovf8;
    logic [2:0]    sel8;
    logic [AW-1:0] addr8;

    ctrl_bus bus4();
    ctrl_bus bus8();

    renkon_ctrl_wb #(.N_CORE(4), .AWIDTH(AW)) dut4 (
        .clk(clk), .xrst(xrst), .in_ctrl(bus4), .out_size(out_size), .out_base(out_base),
        .wb_wbank(wbank4), .wb_rbank(rbank4), .wb_sel(sel4), .mem_we(we4),
        .mem_addr(addr4), .wb_ack(ack4), .wb_ovf(ovf4));

    renkon_ctrl_wb #(.N_CORE(8), .AWIDTH(AW)) dut8 (
        .clk(clk), .xrst(xrst), .in_ctrl(bus8), .out_size(out_size), .out_base(out_base),
        .wb_wbank(wbank8), .wb_rbank(rbank8), .wb_sel(sel8), .mem_we(we8),
        .mem_addr(addr8), .wb_ack(ack8), .wb_ovf(ovf8));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = N_CORE 4, 1 = N_CORE 8
    int  m_base[2], m_plane[2], m_pix[2], m_bank[2], m_ovf[2];
    int  m_last[2], m_prev[2], m_stop[2], m_t0[2];
    bit  m_run[2];
    wr_t exp_w0[$];
    wr_t exp_w1[$];
    int  exp_a0[$];
    int  exp_a1[$];

    function automatic int ncore(int d);
        return (d != 0) ? 8 : 4;
    endfunction

    function automatic int pending(int d);
        return (d != 0) ? (exp_w1.size() + exp_a1.size()) : (exp_w0.size() + exp_a0.size());
    endfunction

    task automatic mon(int d, logic we, logic [AW-1:0] a, int s, logic b, logic ack);
        wr_t e;
        int  ea;
        if (we) begin
            checks++;
            if ((d != 0) ? (exp_w1.size() == 0) : (exp_w0.size() == 0)) begin
                errors++;
                $display("FAIL wr_n%0d unexpected write: cyc=%0d addr=%0d sel=%0d, required none",
                         ncore(d), cyc, a, s);
            end else begin
                e = (d != 0) ? exp_w1.pop_front() : exp_w0.pop_front();
                if (e.cyc != cyc || e.addr != int'(a) || e.sel != s || e.bank != int'(b)) begin
                    errors++;
                    $display("FAIL wr_n%0d: got cyc=%0d addr=%0d sel=%0d bank=%0d, required cyc=%0d addr=%0d sel=%0d bank=%0d",
                             ncore(d), cyc, a, s, b, e.cyc, e.addr, e.sel, e.bank);
                end
            end
        end
        if (ack) begin
            checks++;
            if ((d != 0) ? (exp_a1.size() == 0) : (exp_a0.size() == 0)) begin
                errors++;
                $display("FAIL ack_n%0d unexpected at cyc=%0d", ncore(d), cyc);
            end else begin
                ea = (d != 0) ? exp_a1.pop_front() : exp_a0.pop_front();
                if (ea != cyc || we) begin
                    errors++;
                    $display("FAIL ack_n%0d: got cyc=%0d we=%0d, required cyc=%0d we=0",
                             ncore(d), cyc, we, ea);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!xrst) begin
            mon(0, we4, addr4, int'(sel4), rbank4, ack4);
            mon(1, we8, addr8, int'(sel8), rbank8, ack8);
        end
    end

    task automatic model_reset();
        exp_w0.delete(); exp_w1.delete(); exp_a0.delete(); exp_a1.delete();
        for (int d = 0; d < 2; d++) begin
            m_bank[d] = 0;
            m_run[d]  = 1'b0;
            m_last[d] = -100;
            m_prev[d] = -100;
        end
    endtask

    // One cycle of stimulus on DUT d; the model reacts to what the DUT samples at the next edge.
    task automatic drive(int d, bit st, bit v, bit sp);
        int  t, pend, s, n;
        wr_t w;
        logic wb;
        @(negedge clk);
        t = cyc;
        bus4.start = (d == 0) & st; bus4.valid = (d == 0) & v; bus4.stop = (d == 0) & sp;
        bus8.start = (d == 1) & st; bus8.valid = (d == 1) & v; bus8.stop = (d == 1) & sp;
        if (st && !m_run[d]) begin
            m_run[d]   = 1'b1;
            m_t0[d]    = t;
            m_base[d]  = int'(out_base);
            m_plane[d] = (int'(out_size) * int'(out_size)) % 4096;
            m_pix[d]   = 0;
            m_ovf[d]   = 0;
            m_last[d]  = -100;
            m_prev[d]  = -100;
            m_stop[d]  = -1;
        end else if (m_run[d] && t > m_t0[d]) begin
            if (v) begin
                pend = ((m_last[d] > t) ? 1 : 0) + ((m_prev[d] > t) ? 1 : 0);
                if (pend >= 2) begin
                    m_ovf[d] = 1;
                end else begin
                    wb = (d != 0) ? wbank8 : wbank4;
                    checks++;
                    if (int'(wb) != m_bank[d]) begin
                        errors++;
                        $display("FAIL wbank_n%0d at cyc=%0d: got %0d, required %0d", ncore(d), t, wb, m_bank[d]);
                    end
                    n = ncore(d);
                    s = (t + 1 > m_last[d] + 1) ? t + 1 : m_last[d] + 1;
                    for (int c = 0; c < n; c++) begin
                        w.cyc  = s + c;
                        w.addr = (m_base[d] + m_pix[d] + c * m_plane[d]) % 4096;
                        w.sel  = c;
                        w.bank = m_bank[d];
                        if (d != 0) exp_w1.push_back(w); else exp_w0.push_back(w);
                    end
                    m_prev[d] = m_last[d];
                    m_last[d] = s + n - 1;
                    m_bank[d] = 1 - m_bank[d];
                    m_pix[d]++;
                end
            end
            if (sp && m_stop[d] < 0) m_stop[d] = t;
        end
    endtask

    task automatic finish_run(int d);
        int a, budget;
        logic ov;
        a = ((m_last[d] > m_stop[d]) ? m_last[d] : m_stop[d]) + 2;
        if (d != 0) exp_a1.push_back(a); else exp_a0.push_back(a);
        budget = 0;
        do begin
            drive(d, 1'b0, 1'b0, 1'b0);
            budget++;
        end while (pending(d) != 0 && budget < 400);
        if (pending(d) != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout_n%0d: %0d expected events still outstanding, required 0", ncore(d), pending(d));
            if (d != 0) begin exp_w1.delete(); exp_a1.delete(); end
            else begin exp_w0.delete(); exp_a0.delete(); end
        end
        drive(d, 1'b0, 1'b0, 1'b0);
        ov = (d != 0) ? ovf8 : ovf4;
        checks++;
        if (int'(ov) != m_ovf[d]) begin
            errors++;
            $display("FAIL ovf_n%0d: got %0d, required %0d", ncore(d), ov, m_ovf[d]);
        end
        m_run[d] = 1'b0;
    endtask

    task automatic run_basic(int d, int size, int base, int gap, int nv, bit stop_last);
        out_size = LWIDTH'(size);
        out_base = AW'(base);
        drive(d, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < nv; i++) begin
            drive(d, 1'b0, 1'b1, stop_last && (i == nv - 1));
            if (i < nv - 1) repeat (gap - 1) drive(d, 1'b0, 1'b0, 1'b0);
        end
        if (!stop_last) begin
            drive(d, 1'b0, 1'b0, 1'b0);
            drive(d, 1'b0, 1'b0, 1'b1);
        end
        finish_run(d);
    endtask

    task automatic check_zero(string tag);
        checks++;
        if ({wbank4, rbank4, sel4, we4, addr4, ack4, ovf4} != '0 ||
            {wbank8, rbank8, sel8, we8, addr8, ack8, ovf8} != '0) begin
            errors++;
            $display("FAIL %s: outputs n4=%h n8=%h, required all zero", tag,
                     {wbank4, rbank4, sel4, we4, addr4, ack4, ovf4},
                     {wbank8, rbank8, sel8, we8, addr8, ack8, ovf8});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, len;
        bus4.start = 1'b0; bus4.valid = 1'b0; bus4.stop = 1'b0;
        bus8.start = 1'b0; bus8.valid = 1'b0; bus8.stop = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        xrst = 1'b0;
        repeat (2) @(negedge clk);

        run_basic(0, 2, 100, 10, 4, 1'b0);   // 16 plane-strided writes
        run_basic(0, 3, 10, 2, 2, 1'b0);     // back-to-back, no overflow
        run_basic(1, 2, 200, 1, 3, 1'b0);    // third valid dropped
        run_basic(0, 3, 50, 3, 3, 1'b1);     // stop with last valid
        run_basic(0, 1, 4094, 1, 1, 1'b0);   // address wrap

        // Reset while lane 2 of a pixel is on the bus
        out_size = 8'd2;
        out_base = 12'd100;
        drive(0, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b1, 1'b0);
        repeat (3) drive(0, 1'b0, 1'b0, 1'b0);
        #1 xrst = 1'b1;
        #1 check_zero("reset_mid_write");
        model_reset();
        @(negedge clk);
        xrst = 1'b0;
        repeat (3) drive(0, 1'b0, 1'b0, 1'b0);
        run_basic(0, 2, 300, 1, 2, 1'b0);

        for (int r = 0; r < 14; r++) begin
            d = int'($urandom_range(0, 1));
            out_size = LWIDTH'($urandom_range(1, 15));
            out_base = AW'($urandom_range(0, 4095));
            repeat (2) drive(d, 1'b0, 1'b1, 1'b1);
            drive(d, 1'b1, 1'b0, 1'b0);
            len = int'($urandom_range(4, 30));
            for (int i = 0; i < len; i++) begin
                if (i == len / 2) out_size = LWIDTH'($urandom_range(1, 15));
                drive(d, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, 1'b0);
            end
            drive(d, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
            finish_run(d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
